// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: ld_st_info bit positions, access size codes,
// FSM state encoding and the alignment rule.
package mem_lsu_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned LD_ST_INFO_WIDTH = 5;

  // ld_st_info = {is_load, is_store, size[1:0], unsigned}
  localparam int unsigned LS_IS_LOAD  = 4;
  localparam int unsigned LS_IS_STORE = 3;
  localparam int unsigned LS_SIZE_HI  = 2;
  localparam int unsigned LS_SIZE_LO  = 1;
  localparam int unsigned LS_UNSIGNED = 0;

  typedef enum logic [1:0] {
    LsSizeB = 2'b00,
    LsSizeH = 2'b01,
    LsSizeW = 2'b10
  } ls_size_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StWait = 2'b10,
    StDone = 2'b11
  } lsu_state_e;

  // Unused size code 2'b11 is treated as a word access everywhere.
  function automatic logic is_misaligned(ls_size_e size, logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == LsSizeH) begin
      mis = addr_lo[0];
    end else if (size != LsSizeB) begin
      mis = (addr_lo != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane steering: store byte enables and lane-replicated write data, plus load
// data extraction with sign/zero extension.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  ls_size_e        size_i,
  input  logic [1:0]      offset_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] st_data_i,
  input  logic [XLEN-1:0] ld_data_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] ld_result_o
);

  logic [XLEN-1:0] ld_shifted;

  always_comb begin
    ld_shifted = ld_data_i >> {offset_i, 3'b000};
    be_o        = 4'b1111;
    wdata_o     = st_data_i;
    ld_result_o = ld_shifted;
    unique case (size_i)
      LsSizeB: begin
        be_o        = 4'b0001 << offset_i;
        wdata_o     = {4{st_data_i[7:0]}};
        ld_result_o = {{24{ld_shifted[7] & ~unsigned_i}}, ld_shifted[7:0]};
      end
      LsSizeH: begin
        be_o        = 4'b0011 << {offset_i[1], 1'b0};
        wdata_o     = {2{st_data_i[15:0]}};
        ld_result_o = {{16{ld_shifted[15] & ~unsigned_i}}, ld_shifted[15:0]};
      end
      default: begin
        be_o        = 4'b1111;
        wdata_o     = st_data_i;
        ld_result_o = ld_shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: runs one req/gnt/rvalid data-bus transaction per memory instruction, stalls
// the core while it is in flight, and muxes the extended load data into writeback.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        ex_valid_i,
  input  logic [LD_ST_INFO_WIDTH-1:0] ld_st_info_i,
  input  logic [XLEN-1:0]             ex_agu_mem_addr_i,
  input  logic [XLEN-1:0]             rs2_rdata_i,
  input  logic [XLEN-1:0]             ex_alu_rd_wdata_i,
  output logic                        lsu_stall_o,
  output logic [XLEN-1:0]             lsu_rd_wdata_o,
  output logic                        lsu_rd_we_ok_o,
  output logic                        lsu_exc_o,
  output logic                        dmem_req_o,
  output logic                        dmem_we_o,
  output logic [XLEN-1:0]             dmem_addr_o,
  output logic [3:0]                  dmem_be_o,
  output logic [XLEN-1:0]             dmem_wdata_o,
  input  logic                        dmem_gnt_i,
  input  logic                        dmem_rvalid_i,
  input  logic [XLEN-1:0]             dmem_rdata_i,
  input  logic                        dmem_err_i
);

  localparam int unsigned   CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [3:0]      be_q, be_d;
  logic            we_q, we_d;
  logic            load_q, load_d;
  logic            uns_q, uns_d;
  ls_size_e        size_q, size_d;
  logic            exc_q, exc_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            ex_load, ex_store, ex_uns, mem_op, misaligned;
  ls_size_e        ex_size;
  ls_size_e        al_size;
  logic [1:0]      al_offset;
  logic            al_uns;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata, al_ld_result;

  assign ex_load    = ld_st_info_i[LS_IS_LOAD];
  assign ex_store   = ld_st_info_i[LS_IS_STORE];
  assign ex_uns     = ld_st_info_i[LS_UNSIGNED];
  assign ex_size    = ls_size_e'(ld_st_info_i[LS_SIZE_HI:LS_SIZE_LO]);
  assign mem_op     = ex_valid_i & (ex_load | ex_store);
  assign misaligned = is_misaligned(ex_size, ex_agu_mem_addr_i[1:0]);

  // One aligner serves both directions: EX fields for store steering while IDLE, captured
  // fields for load extraction afterwards.
  assign al_size   = (state_q == StIdle) ? ex_size : size_q;
  assign al_offset = (state_q == StIdle) ? ex_agu_mem_addr_i[1:0] : addr_q[1:0];
  assign al_uns    = (state_q == StIdle) ? ex_uns : uns_q;

  mem_lsu_align u_align (
    .size_i      (al_size),
    .offset_i    (al_offset),
    .unsigned_i  (al_uns),
    .st_data_i   (rs2_rdata_i),
    .ld_data_i   (rdata_q),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .ld_result_o (al_ld_result)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    be_d        = be_q;
    we_d        = we_q;
    load_d      = load_q;
    uns_d       = uns_q;
    size_d      = size_q;
    exc_d       = exc_q;
    cnt_d       = cnt_q;
    lsu_stall_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        exc_d = 1'b0;
        if (mem_op) begin
          lsu_stall_o = 1'b1;
          if (misaligned) begin
            exc_d   = 1'b1;
            load_d  = 1'b0;
            state_d = StDone;
          end else begin
            addr_d  = ex_agu_mem_addr_i;
            we_d    = ex_store;
            be_d    = al_be;
            wdata_d = al_wdata;
            size_d  = ex_size;
            uns_d   = ex_uns;
            load_d  = ex_load;
            cnt_d   = '0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        lsu_stall_o = 1'b1;
        if (dmem_gnt_i) begin
          cnt_d   = '0;
          state_d = StWait;
        end else if (cnt_q == CntLast) begin
          exc_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWait: begin
        lsu_stall_o = 1'b1;
        if (dmem_rvalid_i) begin
          rdata_d = dmem_rdata_i;
          exc_d   = dmem_err_i;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          exc_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      load_q  <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= LsSizeB;
      exc_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      load_q  <= load_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      exc_q   <= exc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dmem_req_o     = (state_q == StReq);
  assign dmem_we_o      = we_q;
  assign dmem_addr_o    = {addr_q[XLEN-1:2], 2'b00};
  assign dmem_be_o      = be_q;
  assign dmem_wdata_o   = wdata_q;
  assign lsu_exc_o      = (state_q == StDone) & exc_q;
  assign lsu_rd_we_ok_o = ~lsu_exc_o;
  assign lsu_rd_wdata_o = ((state_q == StDone) & load_q) ? al_ld_result : ex_alu_rd_wdata_i;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases pinned with literals plus randomized
// instructions and bus timing checked against a transaction-level model.
module tb_mem_lsu;

  logic        clk, rst_n;
  logic        ex_valid;
  logic [4:0]  info;
  logic [31:0] ex_addr, rs2, alu;
  logic        stall, we_ok, exc;
  logic [31:0] rd_wdata;
  logic        req, we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  be;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_wd, got_dw, got_addr;
  logic [3:0]  got_be;

  mem_lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .ex_valid_i        (ex_valid),
    .ld_st_info_i      (info),
    .ex_agu_mem_addr_i (ex_addr),
    .rs2_rdata_i       (rs2),
    .ex_alu_rd_wdata_i (alu),
    .lsu_stall_o       (stall),
    .lsu_rd_wdata_o    (rd_wdata),
    .lsu_rd_we_ok_o    (we_ok),
    .lsu_exc_o         (exc),
    .dmem_req_o        (req),
    .dmem_we_o         (we),
    .dmem_addr_o       (d_addr),
    .dmem_be_o         (be),
    .dmem_wdata_o      (d_wdata),
    .dmem_gnt_i        (gnt),
    .dmem_rvalid_i     (rvalid),
    .dmem_rdata_i      (rdata),
    .dmem_err_i        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain byte-lane arithmetic.
  function automatic logic m_mis(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'd1) return a[0];
    if (sz == 2'd2) return a != 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'd0) return 4'b0001 << a;
    if (sz == 2'd1) return (a >= 2'd2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (sz == 2'd1) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] r, input logic [1:0] sz,
                                         input logic [1:0] a, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    b = r[8*a +: 8];
    h = r[8*a +: 16];
    if (sz == 2'd0) return u ? {24'd0, b} : {{24{b[7]}}, b};
    if (sz == 2'd1) return u ? {16'd0, h} : {{16{h[15]}}, h};
    return r;
  endfunction

  // Runs one instruction, entered #1 after a rising edge. g = REQ cycles before gnt,
  // r = WAIT cycles before rvalid. Every DUT-visible cycle is compared against the model.
  task automatic run_op(input logic ld, input logic st, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] al,
                        input int g, input int r, input logic [31:0] rd, input logic er);
    logic mem, mis, exp_exc, granted;
    ex_valid = 1'b1;
    info     = {ld, st, sz, u};
    ex_addr  = a;
    rs2      = d;
    alu      = al;
    gnt      = 1'b0;
    rvalid   = 1'b0;
    err      = 1'b0;
    mem      = ld | st;
    mis      = m_mis(sz, a[1:0]);
    exp_exc  = mis;
    @(negedge clk);
    if (!mem) begin
      chk("alu_stall", {31'd0, stall}, 32'd0);
      chk("alu_wdata", rd_wdata, al);
      chk("alu_we_ok", {31'd0, we_ok}, 32'd1);
      chk("alu_req", {31'd0, req}, 32'd0);
      @(posedge clk); #1;
      ex_valid = 1'b0;
      return;
    end
    chk("idle_stall", {31'd0, stall}, 32'd1);
    chk("idle_req", {31'd0, req}, 32'd0);
    chk("idle_exc", {31'd0, exc}, 32'd0);
    @(posedge clk); #1;
    if (!mis) begin
      granted = 1'b0;
      for (int k = 0; k < 16 && !granted; k++) begin
        gnt = (k == g);
        @(negedge clk);
        chk("req_req", {31'd0, req}, 32'd1);
        chk("req_stall", {31'd0, stall}, 32'd1);
        chk("req_addr", d_addr, {a[31:2], 2'b00});
        chk("req_be", {28'd0, be}, {28'd0, m_be(sz, a[1:0])});
        chk("req_we", {31'd0, we}, {31'd0, st});
        if (st) chk("req_wdata", d_wdata, m_wdata(sz, d));
        got_addr = d_addr;
        got_be   = be;
        got_dw   = d_wdata;
        @(posedge clk); #1;
        if (gnt) granted = 1'b1;
        gnt = 1'b0;
      end
      if (!granted) begin
        exp_exc = 1'b1;
      end else begin
        for (int j = 0; j <= r; j++) begin
          rvalid = (j == r);
          rdata  = (j == r) ? rd : $urandom;
          err    = (j == r) & er;
          @(negedge clk);
          chk("wait_req", {31'd0, req}, 32'd0);
          chk("wait_stall", {31'd0, stall}, 32'd1);
          @(posedge clk); #1;
          rvalid = 1'b0;
          err    = 1'b0;
        end
        exp_exc = er;
      end
    end
    @(negedge clk);
    chk("done_stall", {31'd0, stall}, 32'd0);
    chk("done_req", {31'd0, req}, 32'd0);
    chk("done_exc", {31'd0, exc}, {31'd0, exp_exc});
    chk("done_we_ok", {31'd0, we_ok}, {31'd0, ~exp_exc});
    if (!exp_exc) chk("done_wdata", rd_wdata, ld ? m_load(rd, sz, a[1:0], u) : al);
    got_wd = rd_wdata;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    chk("after_exc", {31'd0, exc}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; info = '0; ex_addr = '0; rs2 = '0; alu = 32'h1234_5678;
    gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = '0;
    got_wd = '0; got_dw = '0; got_addr = '0; got_be = '0;
    @(negedge clk);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_be", {28'd0, be}, 32'd0);
    chk("rst_exc", {31'd0, exc}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wdata", d_wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases with literal expectations.
    run_op(1, 0, 2'd2, 0, 32'h100, 0, 32'h55, 0, 0, 32'hDEADBEEF, 0);
    chk("lw_lit", got_wd, 32'hDEADBEEF);
    run_op(1, 0, 2'd0, 0, 32'h103, 0, 32'h55, 0, 0, 32'h80123456, 0);
    chk("lb_lit", got_wd, 32'hFFFFFF80);
    run_op(1, 0, 2'd0, 1, 32'h103, 0, 32'h55, 0, 0, 32'h80123456, 0);
    chk("lbu_lit", got_wd, 32'h00000080);
    run_op(1, 0, 2'd1, 0, 32'h102, 0, 32'h55, 0, 0, 32'h80123456, 0);
    chk("lh_lit", got_wd, 32'hFFFF8012);
    run_op(0, 1, 2'd1, 0, 32'h106, 32'h0000ABCD, 32'h77, 0, 0, 0, 0);
    chk("sh_be_lit", {28'd0, got_be}, 32'h0000000C);
    chk("sh_wdata_lit", got_dw, 32'hABCDABCD);
    chk("sh_addr_lit", got_addr, 32'h104);
    run_op(1, 0, 2'd2, 0, 32'h101, 0, 32'h55, 0, 0, 0, 0);
    run_op(1, 0, 2'd2, 0, 32'h108, 0, 32'h55, 5, 1, 32'hCAFEF00D, 0);
    chk("lw_slow_lit", got_wd, 32'hCAFEF00D);
    run_op(0, 1, 2'd2, 0, 32'h10C, 32'h11223344, 32'h66, 99, 0, 0, 0);
    run_op(1, 0, 2'd2, 0, 32'h110, 0, 32'h55, 0, 2, 32'h0BADBAD0, 1);

    // Reset while waiting for rvalid: the late response must be ignored.
    ex_valid = 1'b1; info = {1'b1, 1'b0, 2'd2, 1'b0}; ex_addr = 32'h120; alu = 32'hA5A5A5A5;
    @(posedge clk); #1;
    gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    #2;
    rst_n    = 1'b0;
    ex_valid = 1'b0;
    @(negedge clk);
    chk("rstw_req", {31'd0, req}, 32'd0);
    chk("rstw_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    rvalid = 1'b1;
    rdata  = 32'hFFFFFFFF;
    err    = 1'b1;
    @(negedge clk);
    chk("late_stall", {31'd0, stall}, 32'd0);
    chk("late_exc", {31'd0, exc}, 32'd0);
    chk("late_req", {31'd0, req}, 32'd0);
    chk("late_wdata", rd_wdata, 32'hA5A5A5A5);
    @(posedge clk); #1;
    rvalid = 1'b0; err = 1'b0;

    // Randomized instructions and bus timing.
    for (int n = 0; n < 200; n++) begin
      int kind, g, r;
      logic [1:0] sz;
      kind = $urandom_range(0, 2);
      sz   = 2'($urandom_range(0, 2));
      g    = ($urandom_range(0, 19) == 0) ? 20 : $urandom_range(0, 3);
      r    = $urandom_range(0, 3);
      run_op(kind == 1, kind == 2, sz, 1'($urandom_range(0, 1)),
             32'h100 + 32'($urandom_range(0, 255)), $urandom, $urandom, g, r, $urandom,
             $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
